// File: rtl/fetch_unit_if.sv
// Fetch stage bus: PC pacing, instruction ROM port and decode-side valid/ready handshake.
interface fetch_unit_if;
  localparam int unsigned XW = 16;

  logic [XW-1:0] pc_in;
  logic          pc_inc;
  logic          flush;
  logic [XW-1:0] imem_addr;
  logic          imem_rd;
  logic [XW-1:0] imem_data;
  logic [XW-1:0] ir_out;
  logic [XW-1:0] ir_pc;
  logic          ir_valid;
  logic          ir_ready;
  logic [XW-1:0] stall_cnt;

  // Fetch unit side.
  modport master (
    input  pc_in, flush, imem_data, ir_ready,
    output pc_inc, imem_addr, imem_rd, ir_out, ir_pc, ir_valid, stall_cnt
  );

  // PC / ROM / decode side.
  modport slave (
    output pc_in, flush, imem_data, ir_ready,
    input  pc_inc, imem_addr, imem_rd, ir_out, ir_pc, ir_valid, stall_cnt
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: paces the PC, reads the synchronous ROM and buffers {instr, pc} for decode.
// Optional backpressure counter enabled by defining FETCH_STALL_CNT_EN.
module fetch_unit #(
  parameter int unsigned DEPTH = 4
) (
  input  logic         CLK,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam int unsigned XW = 16;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = CW + 1;

  typedef struct packed {
    logic [XW-1:0] instr;
    logic [XW-1:0] pc;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   head_q;
  logic [AW-1:0]   tail_q;
  logic [CW-1:0]   count_q;
  logic            inflight_q;
  logic [XW-1:0]   inflight_pc_q;

  logic            issue_c;
  logic            push_c;
  logic            pop_c;
  logic            nonempty_c;

  // Issue looks only at registered occupancy so ir_ready never reaches imem_rd/pc_inc.
  always_comb begin
    nonempty_c = (count_q != '0);
    pop_c      = nonempty_c && bus.ir_ready;
    push_c     = inflight_q && !bus.flush;
    issue_c    = reset && !bus.flush &&
                 ((OW'(count_q) + OW'(inflight_q)) < OW'(DEPTH));
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (bus.flush) begin
      // Wrong-path entries and the outstanding read are discarded together.
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      if (push_c) begin
        mem_q[tail_q] <= '{instr: bus.imem_data, pc: inflight_pc_q};
        tail_q        <= tail_q + AW'(1);
      end
      if (pop_c) begin
        head_q <= head_q + AW'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      inflight_q <= issue_c;
      if (issue_c) begin
        inflight_pc_q <= bus.pc_in;
      end
    end
  end

  assign bus.pc_inc    = issue_c;
  assign bus.imem_rd   = issue_c;
  assign bus.imem_addr = bus.pc_in;
  assign bus.ir_valid  = nonempty_c;
  assign bus.ir_out    = nonempty_c ? mem_q[head_q].instr : '0;
  assign bus.ir_pc     = nonempty_c ? mem_q[head_q].pc    : '0;

`ifdef FETCH_STALL_CNT_EN
  logic [XW-1:0] stall_q;

  // Saturating count of cycles where decode holds off a valid head; flush leaves it alone.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (nonempty_c && !bus.ir_ready && (stall_q != '1)) begin
      stall_q <= stall_q + XW'(1);
    end
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: PC/ROM environment, queue-based reference of fetched words, literal spot checks.
module tb_fetch_unit;
  localparam int unsigned DEPTH = 4;

  logic        CLK = 1'b0;
  logic        reset;
  logic [15:0] pc = 16'h0000;
  logic [15:0] jump_tgt = 16'h0000;

  int vectors = 0;
  int miscompares = 0;

  fetch_unit_if bus();

  fetch_unit #(.DEPTH(DEPTH)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // PC register: jump load on flush, otherwise increment on request.
  always @(posedge CLK) begin
    if (bus.flush)       pc <= jump_tgt;
    else if (bus.pc_inc) pc <= pc + 16'd1;
  end
  assign bus.pc_in = pc;

  // Synchronous ROM, ROM[a] = a ^ 0xA5A5; junk when not strobed.
  always @(posedge CLK) begin
    bus.imem_data <= bus.imem_rd ? (bus.imem_addr ^ 16'hA5A5) : 16'hDEAD;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Reference: every issued address becomes a visible entry two cycles later, in order,
  // until it is accepted, flushed or wiped by reset.
  typedef struct {
    logic [15:0] pc;
    int          vis;
  } fetch_t;

  fetch_t      q[$];
  int          cyc = 0;
  logic [15:0] stall_m = 16'h0000;

  always @(negedge CLK) begin
    logic        e_issue, e_valid;
    logic [15:0] e_pc, e_out, e_stall;
    cyc++;
    if (!reset) begin
      q.delete();
      stall_m = 16'h0000;
      e_issue = 1'b0;
    end else begin
      e_issue = !bus.flush && (q.size() < DEPTH);
    end
    e_valid = (q.size() > 0) && (q[0].vis <= cyc);
    e_pc    = e_valid ? q[0].pc : 16'h0000;
    e_out   = e_valid ? (q[0].pc ^ 16'hA5A5) : 16'h0000;
`ifdef FETCH_STALL_CNT_EN
    e_stall = stall_m;
`else
    e_stall = 16'h0000;
`endif
    chk($sformatf("c%0d_imem_rd", cyc),   16'(bus.imem_rd),  16'(e_issue));
    chk($sformatf("c%0d_pc_inc", cyc),    16'(bus.pc_inc),   16'(e_issue));
    chk($sformatf("c%0d_imem_addr", cyc), bus.imem_addr,     pc);
    chk($sformatf("c%0d_ir_valid", cyc),  16'(bus.ir_valid), 16'(e_valid));
    chk($sformatf("c%0d_ir_pc", cyc),     bus.ir_pc,         e_pc);
    chk($sformatf("c%0d_ir_out", cyc),    bus.ir_out,        e_out);
    chk($sformatf("c%0d_stall_cnt", cyc), bus.stall_cnt,     e_stall);
    if (reset) begin
      if (e_valid && !bus.ir_ready && stall_m != 16'hFFFF) stall_m = stall_m + 16'd1;
      if (bus.flush) begin
        q.delete();
      end else begin
        if (e_valid && bus.ir_ready) void'(q.pop_front());
        if (e_issue) q.push_back('{pc: pc, vis: cyc + 2});
      end
    end
  end

  initial begin
    reset        = 1'b0;
    bus.flush    = 1'b0;
    bus.ir_ready = 1'b1;

    // Reset values, then streaming from PC 0.
    repeat (2) @(negedge CLK);
    chk("rst_valid", 16'(bus.ir_valid), 16'h0000);
    chk("rst_out",   bus.ir_out,        16'h0000);
    chk("rst_pc",    bus.ir_pc,         16'h0000);
    chk("rst_rd",    16'(bus.imem_rd),  16'h0000);
    chk("rst_stall", bus.stall_cnt,     16'h0000);
    @(posedge CLK); #1 reset = 1'b1;
    @(negedge CLK);
    chk("first_rd",   16'(bus.imem_rd), 16'h0001);
    chk("first_addr", bus.imem_addr,    16'h0000);
    @(negedge CLK);
    chk("lat_t1_valid", 16'(bus.ir_valid), 16'h0000);
    @(negedge CLK);
    chk("lat_t2_valid", 16'(bus.ir_valid), 16'h0001);
    chk("first_ir_pc",  bus.ir_pc,         16'h0000);
    chk("first_ir_out", bus.ir_out,        16'hA5A5);
    @(negedge CLK);
    chk("second_ir_pc",  bus.ir_pc,  16'h0001);
    chk("second_ir_out", bus.ir_out, 16'hA5A4);
    repeat (6) @(negedge CLK);

    // Backpressure from a fresh start at 0: four issues, then hold at 4; drain in order.
    @(posedge CLK); #1 bus.flush = 1'b1; jump_tgt = 16'h0000; bus.ir_ready = 1'b0;
    @(posedge CLK); #1 bus.flush = 1'b0;
    repeat (7) @(posedge CLK);
    @(negedge CLK);
    chk("full_pc_inc", 16'(bus.pc_inc),   16'h0000);
    chk("full_pc_in",  bus.pc_in,         16'h0004);
    chk("full_valid",  16'(bus.ir_valid), 16'h0001);
    chk("full_head",   bus.ir_pc,         16'h0000);
    @(posedge CLK); #1 bus.ir_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk($sformatf("drain_%0d", i), bus.ir_pc, 16'(i));
    end

    // Flush with three buffered entries and one read outstanding.
    @(posedge CLK); #1 bus.flush = 1'b1; jump_tgt = 16'h0020; bus.ir_ready = 1'b0;
    @(posedge CLK); #1 bus.flush = 1'b0;
    repeat (4) @(posedge CLK);
    #1 bus.flush = 1'b1; jump_tgt = 16'h0100;
    @(negedge CLK);
    chk("preflush_head", bus.ir_pc, 16'h0020);
    @(posedge CLK); #1 bus.flush = 1'b0; bus.ir_ready = 1'b1;
    @(negedge CLK);
    chk("postflush_valid", 16'(bus.ir_valid), 16'h0000);
    chk("target_addr",     bus.imem_addr,     16'h0100);
    @(negedge CLK);
    chk("postflush_valid2", 16'(bus.ir_valid), 16'h0000);
    @(negedge CLK);
    chk("target_ir_pc",  bus.ir_pc,  16'h0100);
    chk("target_ir_out", bus.ir_out, 16'hA4A5);
    repeat (3) @(negedge CLK);

    // Flush coinciding with acceptance of entry 5.
    @(posedge CLK); #1 bus.flush = 1'b1; jump_tgt = 16'h0000;
    @(posedge CLK); #1 bus.flush = 1'b0;
    repeat (7) @(posedge CLK);
    #1 bus.flush = 1'b1; jump_tgt = 16'h0040;
    @(negedge CLK);
    chk("hs_valid", 16'(bus.ir_valid), 16'h0001);
    chk("hs_ir_pc", bus.ir_pc,         16'h0005);
    @(posedge CLK); #1 bus.flush = 1'b0;
    @(negedge CLK);
    chk("hs_after_valid", 16'(bus.ir_valid), 16'h0000);
    @(negedge CLK);
    @(negedge CLK);
    chk("hs_next_ir_pc", bus.ir_pc, 16'h0040);
    repeat (3) @(negedge CLK);

    // Reset with two buffered entries and one in flight; restart with decode stalled.
    @(posedge CLK); #1 bus.flush = 1'b1; jump_tgt = 16'h0200; bus.ir_ready = 1'b0;
    @(posedge CLK); #1 bus.flush = 1'b0;
    repeat (3) @(posedge CLK);
    #1 reset = 1'b0;
    @(negedge CLK);
    chk("midrst_valid",  16'(bus.ir_valid), 16'h0000);
    chk("midrst_out",    bus.ir_out,        16'h0000);
    chk("midrst_pc",     bus.ir_pc,         16'h0000);
    chk("midrst_pc_inc", 16'(bus.pc_inc),   16'h0000);
    repeat (2) @(posedge CLK);
    #1 reset = 1'b1;
    @(negedge CLK);
    chk("rel_rd",   16'(bus.imem_rd), 16'h0001);
    chk("rel_addr", bus.imem_addr,    16'h0203);
    repeat (2) @(negedge CLK);
    chk("rel_ir_pc",  bus.ir_pc,     16'h0203);
    chk("rel_ir_out", bus.ir_out,    16'hA7A6);
    chk("stall_zero", bus.stall_cnt, 16'h0000);
    repeat (10) @(negedge CLK);
`ifdef FETCH_STALL_CNT_EN
    chk("stall_ten", bus.stall_cnt, 16'd10);
`else
    chk("stall_off", bus.stall_cnt, 16'h0000);
`endif
    @(posedge CLK); #1 bus.ir_ready = 1'b1;
    repeat (8) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly downstream of the program counter: it takes the PC value, reads the synchronous instruction ROM, and buffers returned instruction words with their addresses for the decode stage. It paces the PC by driving its `inc` input and discards wrong-path fetches when a jump loads the PC. A valid/ready handshake to decode decouples fetch from downstream stalls.

## Interface
- `DEPTH`, 4: instruction buffer entries; power of two, 2..16.
- `CLK` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low; clears all state immediately.
- `pc_in` input 16: current PC value (PC register output).
- `pc_inc` output 1: increment request to PC, combinational, equals `issue`.
- `flush` input 1: jump taken this cycle; PC `load` asserted in the same cycle.
- `imem_addr` output 16: ROM address, combinationally equal to `pc_in`.
- `imem_rd` output 1: ROM read strobe, equals `issue`.
- `imem_data` input 16: ROM read data, valid the cycle after `imem_rd`.
- `ir_out` output 16: instruction at buffer head.
- `ir_pc` output 16: address of `ir_out`.
- `ir_valid` output 1: buffer head valid.
- `ir_ready` input 1: decode accepts head this cycle.
- `stall_cnt` output 16: backpressure cycle count (see Configuration).

## Operation
- State: circular buffer of `DEPTH` {instr, pc} entries, occupancy `count` (0..DEPTH), flag `inflight` (one read outstanding) with its tagged PC `inflight_pc`.
- `issue = reset_high && !flush && (count + inflight < DEPTH)`; uses registered state only, no combinational path from `ir_ready` to `imem_rd`/`pc_inc`.
- On `issue`: `inflight` set, `inflight_pc <= pc_in`; PC increments on the same edge.
- Cycle after issue: if `inflight` and no `flush`, write {`imem_data`, `inflight_pc`} at tail; `inflight` clears unless a new issue occurs.
- Pop: `ir_valid && ir_ready` advances head. Push and pop in the same cycle leave `count` unchanged.
- `ir_valid = (count != 0)`; `ir_out`/`ir_pc` show head entry; 0 when empty.
- Flush: at next edge `count <= 0`, pointers reset, `inflight <= 0`; data returning in the flush cycle is dropped; no issue in the flush cycle. A handshake completing in the flush cycle counts as accepted. First fetch from the jump target issues the cycle after flush.
- `pc_in` is trusted as-is; fetch at 0xFFFF followed by PC wrap to 0x0000 needs no special handling.

## Timing
- Reset values: `ir_valid` 0, `ir_out` 0x0000, `ir_pc` 0x0000, `imem_rd` 0, `pc_inc` 0, `stall_cnt` 0, `count` 0, `inflight` 0.
- Reset mid-operation: outstanding ROM response is ignored; the first issue occurs in the first cycle with `reset` high.
- Latency: issue at cycle t -> data captured at end of t+1 -> `ir_valid` with that instruction at t+2.
- Throughput: one instruction per cycle sustained when `ir_ready` held high and `DEPTH` >= 4. With `DEPTH` 2, steady-state throughput is 2 of 3 cycles.
- Full: `count + inflight == DEPTH` blocks issue; `pc_in` must hold, guaranteed because `pc_inc` is low.
- Empty with `ir_ready` high: no pop, no underflow.

## Configuration
- `FETCH_STALL_CNT_EN` defined: `stall_cnt` increments on each cycle with `ir_valid && !ir_ready`, saturates at 0xFFFF, cleared only by `reset` (not by `flush`).
- Not defined: no counter register; `stall_cnt` tied to 0x0000.

## Test plan
- Reset release, `pc_in` counting from 0, ROM[a]=a^0xA5A5, `ir_ready`=1: `ir_valid` rises 2 cycles after the first issue, then one entry per cycle with `ir_pc` 0,1,2…, `ir_out` = `ir_pc`^0xA5A5.
- `ir_ready`=0 from start: exactly `DEPTH` issues (4), then `pc_inc` low with `pc_in` held at 4; release `ir_ready` -> entries 0..3 drain in order, fetch resumes at 4.
- `flush` while 3 entries buffered plus one in flight, PC loaded to 0x0100: cycle after `ir_valid`=0, flushed data never appears; next `ir_pc` seen is 0x0100.
- `flush` in the same cycle as an accepted handshake on `ir_pc` 0x0005: entry 5 is consumed once; no later entry from before the flush.
- `reset` low while an entry is in flight and the buffer holds 2 entries: outputs return to reset values immediately; after release the first `ir_pc` equals `pc_in` at first issue.
- With `FETCH_STALL_CNT_EN`, 10 cycles of `ir_valid`=1 and `ir_ready`=0 -> `stall_cnt`=10; without the macro `stall_cnt` stays 0.
